// File: rtl/fir_filter_param_if.sv
// Sample/coefficient bus between a sample source and the parametrised FIR filter.
// The master drives samples and coefficient writes; the slave (filter) returns filtered samples.
interface fir_filter_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
);

  logic                       coef_wr_en;
  logic [$clog2(TAPS)-1:0]    coef_addr;
  logic signed [COEF_W-1:0]   coef_data;
  logic                       in_valid;
  logic signed [DATA_W-1:0]   in_data;
  logic                       out_valid;
  logic signed [DATA_W-1:0]   out_data;
  logic                       out_sat;

  modport master (
    output coef_wr_en, coef_addr, coef_data, in_valid, in_data,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  coef_wr_en, coef_addr, coef_data, in_valid, in_data,
    output out_valid, out_data, out_sat
  );

endinterface

// File: rtl/fir_filter_param.sv
// Pipelined, valid-qualified direct-form FIR with run-time coefficients,
// round-half-up output scaling and saturation. Latency is three edges after the input edge.
module fir_filter_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 0,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  fir_filter_param_if.slave bus
);

  localparam int ADDR_W   = $clog2(TAPS);
  localparam int ADDR_P1  = ADDR_W + 1;
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int RND_W    = ACC_W + 1;
  localparam int SHIFT_M1 = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [ADDR_P1-1:0]      TAPS_LIM = ADDR_P1'(TAPS);
  localparam logic signed [RND_W-1:0] RND_BIAS = (OUT_SHIFT > 0) ? (RND_W'(1) << SHIFT_M1) : '0;
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [RND_W-1:0]  SAT_MAX = RND_W'(OUT_MAX);
  localparam logic signed [RND_W-1:0]  SAT_MIN = RND_W'(OUT_MIN);

  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [DATA_W-1:0] x_d    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]               vld_q, vld_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_valid_q, out_valid_d;
  logic                     coef_hit;
  logic signed [RND_W-1:0]  rnd_sum;
  logic signed [RND_W-1:0]  rnd_shift;

  // S1: delay line only advances on valid samples; out-of-range coefficient addresses are dropped.
  always_comb begin
    coef_hit = bus.coef_wr_en && ({1'b0, bus.coef_addr} < TAPS_LIM);
    for (int k = 0; k < TAPS; k++) begin
      x_d[k]    = x_q[k];
      coef_d[k] = coef_q[k];
    end
    if (bus.in_valid) begin
      x_d[0] = bus.in_data;
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
    end
    if (coef_hit) begin
      coef_d[bus.coef_addr] = bus.coef_data;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PROD_W'(x_q[k]) * PROD_W'(coef_q[k]);
    end
  end

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_d = acc_d + ACC_W'(prod_q[k]);
    end
  end

  assign vld_d = {vld_q[1:0], bus.in_valid};

  // Rounding add is one bit wider than the accumulator so the bias can never wrap.
  always_comb begin
    rnd_sum     = RND_W'(acc_q) + RND_BIAS;
    rnd_shift   = rnd_sum >>> OUT_SHIFT;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = vld_q[2];
    if (vld_q[2]) begin
      if (rnd_shift > SAT_MAX) begin
        out_data_d = OUT_MAX;
        out_sat_d  = 1'b1;
      end else if (rnd_shift < SAT_MIN) begin
        out_data_d = OUT_MIN;
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = rnd_shift[DATA_W-1:0];
        out_sat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
        prod_q[k] <= '0;
      end
      acc_q       <= '0;
      vld_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= x_d[k];
        coef_q[k] <= coef_d[k];
        prod_q[k] <= prod_d[k];
      end
      acc_q       <= acc_d;
      vld_q       <= vld_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: three instances cover the default build,
// OUT_SHIFT=1 rounding and a non-power-of-two tap count.
module tb_fir_filter_param;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fir_filter_param_if #(.DATA_W(16), .COEF_W(16), .TAPS(8)) f0 ();
  fir_filter_param_if #(.DATA_W(16), .COEF_W(16), .TAPS(8)) f1 ();
  fir_filter_param_if #(.DATA_W(16), .COEF_W(16), .TAPS(5)) f2 ();

  fir_filter_param #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(f0)
  );
  fir_filter_param #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(f1)
  );
  fir_filter_param #(.DATA_W(16), .COEF_W(16), .TAPS(5), .OUT_SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .bus(f2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef0(input int addr, input int data);
    f0.coef_wr_en = 1'b1;
    f0.coef_addr  = 3'(addr);
    f0.coef_data  = 16'(data);
    tick();
    f0.coef_wr_en = 1'b0;
  endtask

  task automatic write_coef2(input int addr, input int data);
    f2.coef_wr_en = 1'b1;
    f2.coef_addr  = 3'(addr);
    f2.coef_data  = 16'(data);
    tick();
    f2.coef_wr_en = 1'b0;
  endtask

  // Impulse of 100 followed by seven zeros; output j must be 100*(j+1)*scale.
  task automatic run_impulse0(input string tag, input int scale);
    for (int c = 0; c < 12; c++) begin
      f0.in_valid = (c < 8);
      f0.in_data  = (c == 0) ? 16'sd100 : 16'sd0;
      tick();
      checks++;
      if (c >= 3 && c < 11) begin
        if (f0.out_valid !== 1'b1 || f0.out_data !== 100 * (c - 2) * scale || f0.out_sat !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s[%0d] got valid=%b data=%0d sat=%b expected valid=1 data=%0d sat=0",
                   tag, c - 3, f0.out_valid, f0.out_data, f0.out_sat, 100 * (c - 2) * scale);
        end
      end else begin
        if (f0.out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s_idle cycle %0d got out_valid=%b expected 0", tag, c, f0.out_valid);
        end
      end
    end
    f0.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (f0.out_valid !== 1'b0 || f0.out_data !== 16'sd0 || f0.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut0 got valid=%b data=%0d sat=%b expected 0/0/0", f0.out_valid, f0.out_data, f0.out_sat);
    end
    checks++;
    if (f1.out_valid !== 1'b0 || f1.out_data !== 16'sd0 || f1.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got valid=%b data=%0d sat=%b expected 0/0/0", f1.out_valid, f1.out_data, f1.out_sat);
    end
    checks++;
    if (f2.out_valid !== 1'b0 || f2.out_data !== 16'sd0 || f2.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut2 got valid=%b data=%0d sat=%b expected 0/0/0", f2.out_valid, f2.out_data, f2.out_sat);
    end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < 8; k++) write_coef0(k, k + 1);
    run_impulse0("impulse", 1);
  endtask

  task automatic test_bubbles();
    bit vpat [15];
    int k = 0;
    for (int c = 0; c < 15; c++) vpat[c] = (c == 0) || (c >= 5 && c <= 11);
    for (int c = 0; c < 15; c++) begin
      f0.in_valid = (c < 12) ? vpat[c] : 1'b0;
      f0.in_data  = (c == 0) ? 16'sd10 : 16'sd0;
      tick();
      checks++;
      if (c >= 3 && vpat[c-3]) begin
        if (f0.out_valid !== 1'b1 || f0.out_data !== 10 * (k + 1) || f0.out_sat !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bubbles[%0d] got valid=%b data=%0d sat=%b expected valid=1 data=%0d sat=0",
                   k, f0.out_valid, f0.out_data, f0.out_sat, 10 * (k + 1));
        end
        k++;
      end else if (f0.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bubbles_gap cycle %0d got out_valid=%b expected 0", c, f0.out_valid);
      end
    end
    f0.in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 8; k++) write_coef0(k, 32767);
    for (int c = 0; c < 19; c++) begin
      f0.in_valid = (c < 16);
      f0.in_data  = (c < 8) ? 16'sh7FFF : 16'sh8000;
      tick();
      checks++;
      if ((c >= 3 && c < 19) !== f0.out_valid) begin
        errors++;
        $display("[TB] FAIL sat_valid cycle %0d got out_valid=%b", c, f0.out_valid);
      end
      if (c - 3 == 7) begin
        checks++;
        if (f0.out_data !== 32767 || f0.out_sat !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sat_pos got data=%0d sat=%b expected 32767 sat=1", f0.out_data, f0.out_sat);
        end
      end
      if (c - 3 == 15) begin
        checks++;
        if (f0.out_data !== -32768 || f0.out_sat !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sat_neg got data=%0d sat=%b expected -32768 sat=1", f0.out_data, f0.out_sat);
        end
      end
    end
    f0.in_valid = 1'b0;
  endtask

  task automatic test_rounding();
    f1.coef_wr_en = 1'b1;
    f1.coef_addr  = 3'd0;
    f1.coef_data  = 16'sd1;
    tick();
    f1.coef_wr_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      f1.in_valid = (c < 2);
      f1.in_data  = (c == 0) ? 16'sd3 : -16'sd3;
      tick();
      if (c == 3) begin
        checks++;
        if (f1.out_valid !== 1'b1 || f1.out_data !== 2 || f1.out_sat !== 1'b0) begin
          errors++;
          $display("[TB] FAIL round_pos got valid=%b data=%0d sat=%b expected 1/2/0", f1.out_valid, f1.out_data, f1.out_sat);
        end
      end else if (c == 4) begin
        checks++;
        if (f1.out_valid !== 1'b1 || f1.out_data !== -1 || f1.out_sat !== 1'b0) begin
          errors++;
          $display("[TB] FAIL round_neg got valid=%b data=%0d sat=%b expected 1/-1/0", f1.out_valid, f1.out_data, f1.out_sat);
        end
      end else begin
        checks++;
        if (f1.out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL round_idle cycle %0d got out_valid=%b expected 0", c, f1.out_valid);
        end
      end
    end
    f1.in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 5; c++) begin
      f0.in_valid = 1'b1;
      f0.in_data  = 16'(5 * (c + 1));
      rst = (c == 4);
      tick();
    end
    rst = 1'b0;
    f0.in_valid = 1'b0;
    checks++;
    if (f0.out_valid !== 1'b0 || f0.out_data !== 16'sd0 || f0.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_out got valid=%b data=%0d sat=%b expected 0/0/0", f0.out_valid, f0.out_data, f0.out_sat);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (f0.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_flush cycle %0d got out_valid=%b expected 0", c, f0.out_valid);
      end
    end
    run_impulse0("zero_coef", 0);
    for (int k = 0; k < 8; k++) write_coef0(k, k + 1);
    run_impulse0("reissue", 1);
  endtask

  task automatic test_coef_addr();
    for (int k = 0; k < 5; k++) write_coef2(k, 3 + 2 * k);
    write_coef2(5, 99);
    write_coef2(6, 99);
    write_coef2(7, 99);
    for (int c = 0; c < 9; c++) begin
      f2.in_valid = (c < 5);
      f2.in_data  = (c == 0) ? 16'sd1 : 16'sd0;
      tick();
      checks++;
      if (c >= 3 && c < 8) begin
        if (f2.out_valid !== 1'b1 || f2.out_data !== 3 + 2 * (c - 3) || f2.out_sat !== 1'b0) begin
          errors++;
          $display("[TB] FAIL coef_addr tap %0d got valid=%b data=%0d sat=%b expected data=%0d",
                   c - 3, f2.out_valid, f2.out_data, f2.out_sat, 3 + 2 * (c - 3));
        end
      end else if (f2.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL coef_addr_idle cycle %0d got out_valid=%b expected 0", c, f2.out_valid);
      end
    end
    f2.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    f0.coef_wr_en = 1'b0; f0.coef_addr = '0; f0.coef_data = '0; f0.in_valid = 1'b0; f0.in_data = '0;
    f1.coef_wr_en = 1'b0; f1.coef_addr = '0; f1.coef_data = '0; f1.in_valid = 1'b0; f1.in_data = '0;
    f2.coef_wr_en = 1'b0; f2.coef_addr = '0; f2.coef_data = '0; f2.in_valid = 1'b0; f2.in_data = '0;
    test_reset();
    test_impulse();
    test_bubbles();
    test_saturation();
    test_rounding();
    test_reset_midstream();
    test_coef_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
